// File: rtl/agu_pkg.sv
// Shared types and default parameters for the nested-loop address generator.
package agu_pkg;

    localparam int W_DEF    = 32;
    localparam int DIMS_DEF = 3;
    localparam int CW_DEF   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/agu_dim.sv
// One loop dimension: iteration index, bound, stride and accumulated offset.
// Advances only when a beat occurs and every inner dimension is wrapping.
module agu_dim
    import agu_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic          carry_in,
    input  logic [W-1:0]  stride_in,
    input  logic [CW-1:0] bound_in,
    output logic          at_bound,
    output logic          carry_out,
    output logic [W-1:0]  offset_nxt
);

    logic [CW-1:0] index_q, index_d;
    logic [CW-1:0] bound_q, bound_d;
    logic [W-1:0]  stride_q, stride_d;
    logic [W-1:0]  offset_q, offset_d;

    assign at_bound   = (index_q == bound_q);
    assign carry_out  = carry_in & at_bound;
    // The top registers addr from the post-edge offsets, so expose the next value.
    assign offset_nxt = offset_d;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        index_d  = index_q;
        bound_d  = bound_q;
        stride_d = stride_q;
        offset_d = offset_q;
        if (load) begin
            index_d  = '0;
            offset_d = '0;
            bound_d  = bound_in;
            stride_d = stride_in;
        end else if (step && carry_in) begin
            if (at_bound) begin
                index_d  = '0;
                offset_d = '0;
            end else begin
                index_d  = index_q + 1'b1;
                offset_d = offset_q + stride_q;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q  <= '0;
            bound_q  <= '0;
            stride_q <= '0;
            offset_q <= '0;
        end else begin
            index_q  <= index_d;
            bound_q  <= bound_d;
            stride_q <= stride_d;
            offset_q <= offset_d;
        end
    end

endmodule

// File: rtl/agu_nest.sv
// Multi-dimensional address generator: DIMS nested loops emitting one address
// per accepted beat on a valid/ready stream, with repeat and abort.
module agu_nest
    import agu_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int DIMS = DIMS_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             repeat_mode,
    input  logic [W-1:0]     base,
    input  logic [DIMS*W-1:0]  stride,
    input  logic [DIMS*CW-1:0] bound,
    output logic [W-1:0]     addr,
    output logic             valid,
    input  logic             ready,
    output logic [DIMS-1:0]  dim_last,
    output logic             last,
    output logic             busy
);

    state_e state_q, state_d;
    logic [W-1:0] base_q, base_d;
    logic [W-1:0] addr_q, addr_d;
    logic         repeat_q, repeat_d;
    logic         load, step;
    logic [W-1:0] offset_sum;

    logic [DIMS-1:0]        at_bound, carry_in, carry_out;
    logic [DIMS-1:0][W-1:0] offset_nxt;

    for (genvar g = 0; g < DIMS; g++) begin : g_dim
        if (g == 0) begin : g_first
            assign carry_in[g] = 1'b1;
        end else begin : g_chain
            assign carry_in[g] = carry_out[g-1];
        end

        agu_dim #(.W(W), .CW(CW)) u_dim (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load),
            .step       (step),
            .carry_in   (carry_in[g]),
            .stride_in  (stride[g*W +: W]),
            .bound_in   (bound[g*CW +: CW]),
            .at_bound   (at_bound[g]),
            .carry_out  (carry_out[g]),
            .offset_nxt (offset_nxt[g])
        );
    end

    assign valid    = (state_q == RUN);
    assign busy     = valid;
    assign addr     = addr_q;
    assign dim_last = {DIMS{valid}} & carry_in & at_bound;
    assign last     = valid & carry_out[DIMS-1];

    always_comb begin
        offset_sum = '0;
        for (int d = 0; d < DIMS; d++) begin
            offset_sum = offset_sum + offset_nxt[d];
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        addr_d   = addr_q;
        repeat_d = repeat_q;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    load     = 1'b1;
                    base_d   = base;
                    addr_d   = base;
                    repeat_d = repeat_mode;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (ready) begin
                    // On the final beat every dim wraps, so addr_d lands back on base.
                    step   = 1'b1;
                    addr_d = base_q + offset_sum;
                    if (last && !repeat_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            addr_q   <= '0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            repeat_q <= repeat_d;
        end
    end

endmodule

// File: tb/tb_agu_nest.sv
// Directed bench for agu_nest: table-driven beat sequences plus hand-written
// sequences for abort, start collisions and asynchronous reset.
module tb_agu_nest;

    localparam int W    = 32;
    localparam int DIMS = 3;
    localparam int CW   = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort, repeat_mode, ready;
    logic [W-1:0]      base;
    logic [DIMS*W-1:0]  stride;
    logic [DIMS*CW-1:0] bound;
    logic [W-1:0]      addr;
    logic              valid, last, busy;
    logic [DIMS-1:0]   dim_last;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic         ready;
        logic         valid;
        logic [W-1:0] addr;
        logic [2:0]   dl;
    } vec_t;

    vec_t tab[$];

    always #5 clk = ~clk;

    agu_nest #(.W(W), .DIMS(DIMS), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .repeat_mode (repeat_mode),
        .base        (base),
        .stride      (stride),
        .bound       (bound),
        .addr        (addr),
        .valid       (valid),
        .ready       (ready),
        .dim_last    (dim_last),
        .last        (last),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [W-1:0] a,
                                input logic [2:0] dl);
        vec_t x;
        x.ready = r;
        x.valid = v;
        x.addr  = a;
        x.dl    = dl;
        return x;
    endfunction

    // Called just after a falling edge; start is sampled on the following rising edge.
    task automatic launch(input logic [W-1:0] b, input logic [W-1:0] s0, input logic [W-1:0] s1,
                          input logic [CW-1:0] b0, input logic [CW-1:0] b1, input logic rpt);
        base        = b;
        stride      = {32'h0, s1, s0};
        bound       = {16'h0, b1, b0};
        repeat_mode = rpt;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        base        = 32'hDEAD_BEEF;
        stride      = {3{32'h1234_5678}};
        bound       = {3{16'h00FF}};
        repeat_mode = ~rpt;
    endtask

    task automatic run_rows(input string tag, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            check($sformatf("%s[%0d].valid", tag, i - lo), valid, tab[i].valid);
            check($sformatf("%s[%0d].busy", tag, i - lo), busy, tab[i].valid);
            check($sformatf("%s[%0d].dim_last", tag, i - lo), dim_last, tab[i].dl);
            check($sformatf("%s[%0d].last", tag, i - lo), last, tab[i].dl[2]);
            if (tab[i].valid) check($sformatf("%s[%0d].addr", tag, i - lo), addr, tab[i].addr);
            ready = tab[i].ready;
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, valid, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".last"}, last, 0);
        check({tag, ".dim_last"}, dim_last, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a2d [6];
        logic [2:0]   dl2d [6];
        a2d  = '{32'h100, 32'h104, 32'h108, 32'h140, 32'h144, 32'h148};
        dl2d = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b111};

        // rows 0..6: 2-D pattern, ready held high
        for (int k = 0; k < 6; k++) tab.push_back(mk(1'b1, 1'b1, a2d[k], dl2d[k]));
        tab.push_back(mk(1'b0, 1'b0, 32'h0, 3'b000));
        // rows 7..19: same pattern, ready alternating 0,1
        for (int k = 0; k < 6; k++) begin
            tab.push_back(mk(1'b0, 1'b1, a2d[k], dl2d[k]));
            tab.push_back(mk(1'b1, 1'b1, a2d[k], dl2d[k]));
        end
        tab.push_back(mk(1'b0, 1'b0, 32'h0, 3'b000));
        // rows 20..26: repeat mode, 1-D bound 2
        for (int k = 0; k < 7; k++)
            tab.push_back(mk(1'b1, 1'b1, W'(k % 3), (k % 3 == 2) ? 3'b111 : 3'b000));
        // rows 27..31: negative stride wraps modulo 2^W
        tab.push_back(mk(1'b1, 1'b1, 32'h8, 3'b000));
        tab.push_back(mk(1'b1, 1'b1, 32'h4, 3'b000));
        tab.push_back(mk(1'b1, 1'b1, 32'h0, 3'b000));
        tab.push_back(mk(1'b1, 1'b1, 32'hFFFF_FFFC, 3'b111));
        tab.push_back(mk(1'b0, 1'b0, 32'h0, 3'b000));

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; repeat_mode = 1'b0; ready = 1'b0;
        base = '0; stride = '0; bound = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset.addr", addr, 0);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        launch(32'h100, 32'h4, 32'h40, 16'd2, 16'd1, 1'b0);
        run_rows("seq2d", 0, 6);
        // relaunch straight from the idle cycle: minimum one-cycle gap
        launch(32'h100, 32'h4, 32'h40, 16'd2, 16'd1, 1'b0);
        run_rows("stall", 7, 19);

        launch(32'h0, 32'h1, 32'h0, 16'd2, 16'd0, 1'b1);
        run_rows("rpt", 20, 26);
        check("rpt.pre_abort.addr", addr, 32'h1);
        abort = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort");
        @(negedge clk);
        check("abort.stay.valid", valid, 0);

        launch(32'h8, 32'hFFFF_FFFC, 32'h0, 16'd3, 16'd0, 1'b0);
        run_rows("negstr", 27, 31);

        // start and abort together in IDLE: abort wins
        base = 32'h500; bound = '0; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check_idle("start_abort");
        @(negedge clk);
        check("start_abort.stay.valid", valid, 0);

        // start while running is ignored
        ready = 1'b1;
        launch(32'h100, 32'h4, 32'h40, 16'd2, 16'd1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("run_start[%0d].addr", k), addr, a2d[k]);
            check($sformatf("run_start[%0d].dim_last", k), dim_last, dl2d[k]);
            start = (k < 4);
            base  = 32'h900;
            @(negedge clk);
        end
        start = 1'b0;
        check_idle("run_start.end");

        // asynchronous reset mid-pattern
        launch(32'h8, 32'hFFFF_FFFC, 32'h0, 16'd3, 16'd0, 1'b0);
        @(negedge clk);
        check("rst_mid.pre.addr", addr, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.addr", addr, 0);
        check_idle("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(32'h8, 32'hFFFF_FFFC, 32'h0, 16'd3, 16'd0, 1'b0);
        check("rst_restart[0].addr", addr, 32'h8);
        check("rst_restart[0].valid", valid, 1);
        @(negedge clk);
        check("rst_restart[1].addr", addr, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/agu_nest.md
# agu_nest

Multi-dimensional address generation unit, the parametrised successor to the single-loop AGU: DIMS nested loops, each with its own iteration bound and stride, producing one address per beat on a valid/ready stream. Sits between the controller (which issues start, base, strides and bounds) and a memory port or SRAM read/write sequencer. It adds per-dimension wrap flags, a repeat mode and abort, none of which the single-loop generator has.

## Interface
- W, 32: address/stride width.
- DIMS, 3: number of nested loops, ≥1; dim 0 is innermost.
- CW, 16: per-dimension counter width.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; latches config and begins a pattern when idle.
- abort  in  1  pulse; terminates the current pattern.
- repeat_mode  in  1  latched at start; 1 = restart pattern after final beat.
- base  in  W  start address.
- stride  in  DIMS*W  per-dim stride, dim d at [d*W +: W], two's complement.
- bound  in  DIMS*CW  per-dim iterations minus one, dim d at [d*CW +: CW].
- addr  out  W  current address.
- valid  out  1  addr is valid.
- ready  in  1  consumer accepts the beat when valid&ready.
- dim_last  out  DIMS  bit d = dim d index equals its bound on the current beat.
- last  out  1  current beat is the final beat of the pattern.
- busy  out  1  pattern in progress.

## Operation
- States: IDLE, RUN. Reset → IDLE.
- IDLE: start&!abort → latch base/stride/bound/repeat_mode, all indices and offsets 0, addr=base, valid=1, busy=1, → RUN. Config inputs are ignored outside this event.
- RUN, beat = valid&ready: dim 0 index increments; where index_d==bound_d it wraps to 0, offset_d → 0 and the carry goes to dim d+1; otherwise index_d+1 and offset_d += stride_d. Dims above the first non-wrapping dim hold.
- addr = base + Σ offset_d, all mod 2^W. Registered; the next value is computed in the same cycle as the beat.
- dim_last[d] = valid & (index_d==bound_d) for all j≤d as well as d itself, i.e. set when dim d wraps on this beat. last = dim_last[DIMS-1].
- Beat with last: repeat_mode=0 → IDLE, valid=0, busy=0. repeat_mode=1 → all indices 0, addr=base, stay in RUN.
- ready=0: addr, valid, dim_last and last hold stable (AXI-style; valid is never withdrawn except by abort).
- abort: in RUN → IDLE next edge, valid=0, busy=0; the beat in that cycle is discarded even if ready=1. In IDLE it has no effect and has priority over a simultaneous start.
- start while in RUN is ignored.
- bound_d=0: dim d has one iteration and always carries.
- Total beats per pattern = Π(bound_d+1).

## Timing
- Reset values: addr=0, valid=0, busy=0, last=0, dim_last=0; all internal counters and offsets 0.
- start at edge n → valid=1, addr=base after edge n; first beat possible in cycle n+1.
- One beat per cycle sustained with ready held high; no bubbles at dim wraps or in repeat restarts.
- Transition from last beat to IDLE: valid=0 after the same edge. A new start is accepted the following cycle, giving a 1-cycle minimum gap.
- rst_n low at any time forces reset values asynchronously; the pattern is lost.

## Structure
- Package agu_pkg: state enum (IDLE, RUN) and default values for W/DIMS/CW.
- Sub-module agu_dim: one dimension. Holds index, bound, stride and offset registers. Inputs: step, carry_in, load. Outputs: at_bound, carry_out, offset. Instantiated DIMS times in a generate loop.
- Top level: FSM, base register, offset adder tree, output registers.

## Test plan
- DIMS=2, base=0x100, stride={0x40,0x4}, bound={1,2}, ready=1 → addr 0x100,0x104,0x108,0x140,0x144,0x148; dim_last[0] on beats 3 and 6; last on beat 6; busy drops after it.
- Same config, ready toggled 1010… → same address sequence, outputs stable while ready=0, 12 cycles total.
- repeat_mode=1, DIMS=1, bound=2, stride=1, base=0 → 0,1,2,0,1,2… with no gap; abort mid-stream → valid=0 next cycle.
- Negative stride 0xFFFFFFFC, base=0x8, bound=3 → 0x8,0x4,0x0,0xFFFFFFFC (wrap mod 2^W).
- start+abort same cycle in IDLE → stays IDLE. start during RUN → ignored, sequence unchanged.
- rst_n asserted mid-pattern → all outputs 0 immediately. After release, start → sequence restarts from base.
